// File: rtl/commit_packet_arb_pkg.sv
// Shared types and helpers for the packet-aware commit lane arbiter.
// Holds the arbiter state encoding, the index-width helper and the typed beat view.
package commit_packet_arb_pkg;

    localparam int COMMIT_DATAW = 64;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Typed view of one commit beat; the lane payload width is COMMIT_DATAW.
    typedef struct packed {
        logic [COMMIT_DATAW-1:0] data;
        logic                    sop;
        logic                    eop;
    } commit_beat_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// rr_ptr+1, wrapping modulo NUM_REQS. Returns a one-hot grant and its index.
module commit_rr_picker
    import commit_packet_arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int SELW     = sel_width(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] req,
    input  logic [SELW-1:0]     rr_ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [SELW-1:0]     idx
);

    logic found;
    int   cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQS;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = SELW'(cand);
            end
        end
    end

endmodule

// File: rtl/commit_packet_arb.sv
// Packet-aware round-robin arbiter sharing one commit lane between NUM_REQS units:
// holds the grant sop..eop, adds starvation aging and one output register stage.
module commit_packet_arb
    import commit_packet_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = COMMIT_DATAW,
    parameter int STARVE_LIMIT = 15,
    parameter int SELW         = sel_width(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    output logic [NUM_REQS-1:0]       ready_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    input  logic [NUM_REQS-1:0]       sop_in,
    input  logic [NUM_REQS-1:0]       eop_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [DATAW-1:0]          data_out,
    output logic                      sop_out,
    output logic                      eop_out,
    output logic [SELW-1:0]           sel_out,
    output logic                      locked,
    output logic                      proto_err
);

    localparam int              CNTW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNTW-1:0] STARVE_MAX = CNTW'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0]     lock_idx_q, lock_idx_d;
    logic [CNTW-1:0]     starve_q [NUM_REQS];
    logic                proto_err_q;

    commit_beat_t        beat_in [NUM_REQS];
    commit_beat_t        acc_beat;
    commit_beat_t        out_q;
    logic                out_valid_q;
    logic [SELW-1:0]     out_sel_q;

    logic [NUM_REQS-1:0] rr_grant, grant, accept;
    logic [SELW-1:0]     rr_idx, starve_idx, grant_idx;
    logic                starve_hit, slot_free, acc_any, proto_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            beat_in[i].data = data_in[i*DATAW +: DATAW];
            beat_in[i].sop  = sop_in[i];
            beat_in[i].eop  = eop_in[i];
        end
    end

    commit_rr_picker #(
        .NUM_REQS(NUM_REQS),
        .SELW    (SELW)
    ) u_picker (
        .req   (valid_in),
        .rr_ptr(rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Scan downward so the lowest saturated requester is the one left standing.
    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (valid_in[i] && starve_q[i] == STARVE_MAX) begin
                starve_hit = 1'b1;
                starve_idx = SELW'(i);
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state_q == ARB_LOCKED) begin
            grant[lock_idx_q] = 1'b1;
            grant_idx         = lock_idx_q;
        end else if (starve_hit) begin
            grant[starve_idx] = 1'b1;
            grant_idx         = starve_idx;
        end else begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end
    end

    assign slot_free = !out_valid_q || ready_out;
    assign ready_in  = grant & {NUM_REQS{slot_free}};
    assign accept    = valid_in & ready_in;
    assign acc_any   = |accept;
    assign acc_beat  = beat_in[grant_idx];
    assign proto_hit = acc_any && ((state_q == ARB_IDLE   && !acc_beat.sop) ||
                                   (state_q == ARB_LOCKED &&  acc_beat.sop));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (acc_any) begin
            case (state_q)
                ARB_IDLE: begin
                    if (!acc_beat.eop) begin
                        state_d    = ARB_LOCKED;
                        lock_idx_d = grant_idx;
                    end else begin
                        rr_ptr_d = grant_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (acc_beat.eop) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = lock_idx_q;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= SELW'(NUM_REQS - 1);
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            if (proto_hit) begin
                proto_err_q <= 1'b1;
            end
            if (acc_any) begin
                out_valid_q <= 1'b1;
                out_q       <= acc_beat;
                out_sel_q   <= grant_idx;
            end else if (ready_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: the starve counters are a small register array, not RAM, so they take the reset like any flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (accept[i]) begin
                    starve_q[i] <= '0;
                end else if (valid_in[i] && starve_q[i] != STARVE_MAX) begin
                    starve_q[i] <= starve_q[i] + 1'b1;
                end
            end
        end
    end

    assign valid_out = out_valid_q;
    assign data_out  = out_q.data;
    assign sop_out   = out_q.sop;
    assign eop_out   = out_q.eop;
    assign sel_out   = out_sel_q;
    assign locked    = (state_q == ARB_LOCKED);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_commit_packet_arb.sv
// Self-checking bench for commit_packet_arb: table vectors, directed corner
// sequences and randomized packet traffic against a behavioural lane model.
module tb_commit_packet_arb;
    import commit_packet_arb_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int LIM = 3;
    localparam int SW  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    valid_in, ready_in, sop_in, eop_in;
    logic [N*DW-1:0] data_in;
    logic [DW-1:0]   d_in [N];
    logic            valid_out, ready_out, sop_out, eop_out, locked, proto_err;
    logic [DW-1:0]   data_out;
    logic [SW-1:0]   sel_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = d_in[i];
    end

    commit_packet_arb #(
        .NUM_REQS    (N),
        .DATAW       (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_in  (data_in),
        .sop_in   (sop_in),
        .eop_in   (eop_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .data_out (data_out),
        .sop_out  (sop_out),
        .eop_out  (eop_out),
        .sel_out  (sel_out),
        .locked   (locked),
        .proto_err(proto_err)
    );

    // Lane model: packet ownership, fairness pointer, wait ages, output slot.
    bit            m_locked, m_ov, m_os, m_oe, m_perr;
    int            m_owner, m_rr, m_osel;
    int            m_starve [N];
    logic [DW-1:0] m_od;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_locked) return m_owner;
        for (int i = 0; i < N; i++)
            if (valid_in[i] && m_starve[i] == LIM) return i;
        for (int k = 1; k <= N; k++)
            if (valid_in[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = N - 1;
        m_ov = 0; m_os = 0; m_oe = 0; m_perr = 0; m_osel = 0; m_od = '0;
        for (int i = 0; i < N; i++) m_starve[i] = 0;
    endtask

    task automatic clear_inputs();
        valid_in = '0; sop_in = '0; eop_in = '0;
        for (int i = 0; i < N; i++) d_in[i] = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        valid_in[i] = v; sop_in[i] = s; eop_in[i] = e; d_in[i] = d;
    endtask

    task automatic check_outputs();
        check("valid_out", DW'(valid_out), DW'(m_ov));
        check("locked", DW'(locked), DW'(m_locked));
        check("proto_err", DW'(proto_err), DW'(m_perr));
        if (m_ov) begin
            check("data_out", data_out, m_od);
            check("sop_out", DW'(sop_out), DW'(m_os));
            check("eop_out", DW'(eop_out), DW'(m_oe));
            check("sel_out", DW'(sel_out), DW'(m_osel));
        end
    endtask

    // One clock: check ready_in mid-cycle, advance the model, check registered outputs after the edge.
    task automatic tick(output int acc, output logic [N-1:0] rdy);
        int           g;
        bit           slot;
        logic [N-1:0] er;
        @(negedge clk);
        g    = model_grant();
        slot = !m_ov || ready_out;
        er   = '0;
        if (g >= 0 && slot) er[g] = 1'b1;
        rdy = ready_in;
        check("ready_in", DW'(ready_in), DW'(er));
        acc = (g >= 0 && slot && valid_in[g]) ? g : -1;
        for (int i = 0; i < N; i++) begin
            if (i == acc) m_starve[i] = 0;
            else if (valid_in[i] && m_starve[i] < LIM) m_starve[i]++;
        end
        if (acc >= 0) begin
            if (m_locked ? sop_in[acc] : !sop_in[acc]) m_perr = 1;
            if (!m_locked && !eop_in[acc]) begin
                m_locked = 1; m_owner = acc;
            end else if (eop_in[acc]) begin
                m_locked = 0; m_rr = acc;
            end
            m_ov = 1; m_od = d_in[acc]; m_os = sop_in[acc]; m_oe = eop_in[acc]; m_osel = acc;
        end else if (ready_out) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        ready_out = 1'b1;
        model_reset();
        #1;
        check("rst_valid_out", DW'(valid_out), '0);
        check("rst_data_out", data_out, '0);
        check("rst_sop_eop", DW'({sop_out, eop_out}), '0);
        check("rst_sel_out", DW'(sel_out), '0);
        check("rst_locked", DW'(locked), '0);
        check("rst_proto_err", DW'(proto_err), '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  exp_ready;
        logic          exp_vout;
        logic [SW-1:0] exp_sel;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           acc, lk;
        logic [N-1:0] rdy;
        int           g_left [N];
        bit           g_first [N];

        tbl[0] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[2] = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[3] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[4] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[5] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[6] = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[7] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[8] = '{4'b1111, 4'b1000, 1'b1, 2'd3};

        // Single-beat round robin, all requesters valid.
        apply_reset();
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < N; i++)
                set_req(i, tbl[r].valid[i], tbl[r].valid[i], tbl[r].valid[i], DW'(64'h1000 * r + i));
            tick(acc, rdy);
            check("tbl_ready", DW'(rdy), DW'(tbl[r].exp_ready));
            check("tbl_vout", DW'(valid_out), DW'(tbl[r].exp_vout));
            if (tbl[r].exp_vout) check("tbl_sel", DW'(sel_out), DW'(tbl[r].exp_sel));
        end

        // Three-beat packet from req1 keeps req2 out until eop.
        apply_reset();
        lk = 0;
        set_req(2, 1, 1, 1, 64'hB2);
        set_req(1, 1, 1, 0, 64'hA1);
        tick(acc, rdy); check("pkt_b0_ready", DW'(rdy), DW'(4'b0010)); lk += int'(locked);
        set_req(1, 1, 0, 0, 64'hA2);
        tick(acc, rdy); check("pkt_b1_ready", DW'(rdy), DW'(4'b0010)); lk += int'(locked);
        check("pkt_b1_data", data_out, 64'hA2);
        set_req(1, 1, 0, 1, 64'hA3);
        tick(acc, rdy); check("pkt_b2_ready", DW'(rdy), DW'(4'b0010)); lk += int'(locked);
        check("pkt_b2_sel", DW'(sel_out), DW'(1));
        set_req(1, 0, 0, 0, '0);
        tick(acc, rdy); check("pkt_next_ready", DW'(rdy), DW'(4'b0100)); lk += int'(locked);
        check("pkt_next_sel", DW'(sel_out), DW'(2));
        check("pkt_lock_cycles", DW'(lk), DW'(2));

        // Back-pressure holds the registered beat and the fairness pointer.
        apply_reset();
        ready_out = 1'b0;
        set_req(0, 1, 1, 1, 64'hD0);
        tick(acc, rdy); check("bp_fill_ready", DW'(rdy), DW'(4'b0001));
        set_req(0, 0, 0, 0, '0);
        set_req(1, 1, 1, 1, 64'hD1);
        set_req(2, 1, 1, 1, 64'hD2);
        for (int c = 0; c < 5; c++) begin
            tick(acc, rdy);
            check("bp_stall_ready", DW'(rdy), '0);
            check("bp_stall_data", data_out, 64'hD0);
            check("bp_stall_sel", DW'(sel_out), '0);
        end
        ready_out = 1'b1;
        tick(acc, rdy); check("bp_resume_ready", DW'(rdy), DW'(4'b0010));
        check("bp_resume_data", data_out, 64'hD1);
        set_req(1, 0, 0, 0, '0);
        tick(acc, rdy); check("bp_next_ready", DW'(rdy), DW'(4'b0100));

        // Req3 ages to the limit during req0's 8-beat packet and wins next.
        apply_reset();
        set_req(3, 1, 1, 1, 64'h33);
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1, k == 0, k == 7, DW'(64'h500 + k));
            if (k == 7) begin
                set_req(1, 1, 1, 1, 64'h11);
                set_req(2, 1, 1, 1, 64'h22);
            end
            tick(acc, rdy);
            check("starve_pkt_ready", DW'(rdy), DW'(4'b0001));
        end
        set_req(0, 0, 0, 0, '0);
        tick(acc, rdy); check("starve_win_ready", DW'(rdy), DW'(4'b1000));
        check("starve_win_sel", DW'(sel_out), DW'(3));
        set_req(3, 0, 0, 0, '0);
        tick(acc, rdy); check("starve_after_ready", DW'(rdy), DW'(4'b0010));

        // Accept in IDLE without sop flags a sticky error that only reset clears.
        apply_reset();
        set_req(2, 1, 0, 1, 64'hEE);
        tick(acc, rdy); check("perr_ready", DW'(rdy), DW'(4'b0100));
        check("perr_set", DW'(proto_err), DW'(1));
        check("perr_beat_data", data_out, 64'hEE);
        set_req(2, 0, 0, 0, '0);
        for (int c = 0; c < 3; c++) tick(acc, rdy);
        #2;
        reset = 1'b0;
        #1;
        check("perr_cleared", DW'(proto_err), '0);

        // Async reset mid-packet drops the lock and the registered beat.
        apply_reset();
        ready_out = 1'b0;
        set_req(1, 1, 1, 0, 64'h71);
        tick(acc, rdy);
        set_req(1, 1, 0, 0, 64'h72);
        tick(acc, rdy);
        check("mid_locked_before", DW'({locked, valid_out}), DW'(2'b11));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid_out", DW'(valid_out), '0);
        check("mid_rst_locked", DW'(locked), '0);
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 1, DW'(64'h900 + i));
        tick(acc, rdy); check("mid_first_grant", DW'(rdy), DW'(4'b0001));

        // Randomized well-formed packet traffic with random back-pressure.
        apply_reset();
        for (int i = 0; i < N; i++) begin g_left[i] = 0; g_first[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid_in[i]) begin
                    if (g_left[i] == 0 && $urandom_range(3) == 0) begin
                        g_left[i]  = $urandom_range(1, 4);
                        g_first[i] = 1;
                    end
                    if (g_left[i] > 0 && $urandom_range(2) != 0)
                        set_req(i, 1, g_first[i], g_left[i] == 1, {$urandom, $urandom});
                end
            end
            ready_out = ($urandom_range(3) != 0);
            tick(acc, rdy);
            if (acc >= 0) begin
                valid_in[acc] = 1'b0;
                g_left[acc]--;
                g_first[acc] = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_packet_arb.md
Name: commit_packet_arb

Overview:
- Packet-aware arbiter that shares one commit/writeback lane between NUM_REQS execution-unit commit streams (ALU, LSU, FPU, SFU).
- Grants round-robin and holds the grant from a packet's first beat through its eop beat, so multi-beat sop..eop results are never interleaved.
- Adds starvation-priority aging and one output register stage.
- Sits per issue slot, between the execution units' commit outputs and the commit/writeback stage.

Parameters:
- NUM_REQS, 4, number of requesting units (>=1).
- DATAW, 64, payload bits per beat, excluding sop/eop.
- STARVE_LIMIT, 15, cycles a valid, unserved requester waits before forced priority (>=1).
- SELW, $clog2(NUM_REQS) (1 when NUM_REQS=1), derived index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  NUM_REQS  per-requester beat valid.
- ready_in  out  NUM_REQS  per-requester beat accepted.
- data_in  in  NUM_REQS*DATAW  per-requester payload; requester i at bits [i*DATAW +: DATAW].
- sop_in  in  NUM_REQS  first beat of packet.
- eop_in  in  NUM_REQS  last beat of packet.
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accept.
- data_out  out  DATAW  registered payload.
- sop_out  out  1  registered sop.
- eop_out  out  1  registered eop.
- sel_out  out  SELW  index of the requester that produced the current output beat.
- locked  out  1  high while in LOCKED state.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync deassert) sets:
  - valid_out, sop_out, eop_out, locked, proto_err = 0
  - data_out = 0, sel_out = 0
  - state = IDLE, rr_ptr = NUM_REQS-1 (requester 0 wins first), all starve counters = 0
- Reset mid-packet drops the lock and any registered beat; no replay.
- Handshake:
  - Output slot is free when !valid_out || ready_out.
  - ready_in[i] = grant[i] && slot free.
  - Accept for requester i = valid_in[i] && ready_in[i]; at most one accept per cycle.
  - ready_in[i] never depends on valid_in[i] of the same index beyond arbitration; a requester must hold valid/data until it is accepted.
- Latency: an accepted beat appears on valid_out/data_out/sop_out/eop_out/sel_out the next cycle.
- Output register holds its values while valid_out && !ready_out. It clears valid_out when ready_out is high and there is no accept that cycle.
- IDLE state grant:
  - If any valid requester has starve_cnt == STARVE_LIMIT, grant the lowest such index.
  - Otherwise grant the first valid requester searching upward from rr_ptr+1, wrapping modulo NUM_REQS.
- IDLE, accepted beat with eop=0: go to LOCKED, lock_idx = i.
- IDLE, accepted beat with eop=1 (single-beat packet): stay IDLE, rr_ptr = i.
- LOCKED state:
  - grant is only lock_idx; all other ready_in = 0 regardless of starvation.
  - Accepted beat with eop=1: go to IDLE and set rr_ptr = lock_idx. The next grant is made in the following cycle (no same-cycle re-grant).
- Starve counter, per requester, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, each cycle valid_in[i] && !accept[i].
  - Clears to 0 on accept[i].
  - Holds when valid_in[i] = 0.
- proto_err is set, and stays set until reset, on either of:
  - an accept in IDLE with sop=0;
  - an accept in LOCKED with sop=1.
- The beat is still forwarded on error, and the state machine proceeds normally.
- NUM_REQS=1: requester 0 is always granted; otherwise identical, including register stage and lock tracking.
- Back-pressure does not advance rr_ptr; only eop accepts do.

Decomposition:
- Shared package holds:
  - the state enum (ARB_IDLE, ARB_LOCKED);
  - the SELW derivation function;
  - the commit beat struct {data, sop, eop} used for typed views of data_in/data_out.
- Sub-module commit_rr_picker: combinational round-robin priority picker (inputs: request mask, rr_ptr; outputs: one-hot grant, index).
- The starvation override and the FSM stay in the parent.

Test Plan:
- Four requesters, single-beat packets (sop=eop=1), all valid continuously, ready_out=1 -> grants in order 0,1,2,3,0,… one per cycle; valid_out high from cycle 2 on; sel_out follows 1 cycle behind the grant.
- Req1 sends a 3-beat packet while req2 is continuously valid -> sel_out shows 1,1,1 then 2; ready_in[2]=0 throughout req1's packet; locked=1 for exactly 2 cycles.
- ready_out=0 for 5 cycles with a beat registered -> data_out/sel_out stable; no ready_in high after the beat that filled the slot; rr_ptr unchanged; delivery resumes with the correct data when ready_out=1.
- STARVE_LIMIT=3: req0 sends an 8-beat packet while req3 waits -> req3 counter saturates at 3; req3 is granted first after req0's eop, ahead of req1/req2 even though rr order favours req1.
- Accept in IDLE with sop=0 -> proto_err=1 next cycle, beat still output; proto_err remains 1 until reset is asserted low, then reads 0.
- Assert reset mid-packet (locked=1, valid_out=1) -> asynchronously valid_out=0, locked=0; after deassert, requester 0 wins the first grant.
